// File: rtl/mio_arb_pkg.sv
// mio_arb_pkg: shared constants for the two-master MIO port arbiter.
//   - FSM state encodings (IDLE / ACCESS / RESP)
//   - master index constants (M_CPU = 0, M_AUX = 1)
//   - default timeout and timeout counter width
//   - helper that turns a master index into a one-hot acknowledge vector
// Optional feature macro used by the files importing this package: MIO_ARB_RR_EN
package mio_arb_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Master indices
   localparam logic M_CPU = 1'b0;
   localparam logic M_AUX = 1'b1;

   // Timeout defaults: an 8-bit counter bounds TIMEOUT to 1..255
   localparam int CNT_W           = 8;
   localparam int MIO_TIMEOUT_DEF = 255;

   // One-hot acknowledge vector {m1, m0} for the given master index
   function automatic logic [1:0] owner_onehot(input logic idx);
      logic [1:0] vec;
      if (idx == M_AUX) begin
         vec = 2'b10;
      end else begin
         vec = 2'b01;
      end
      return vec;
   endfunction

endpackage

// File: rtl/mio_arb_pick.sv
// mio_arb_pick: combinational winner select between two MIO masters.
//   Ports:
//     req0, req1   in   request lines of master 0 (CPU) and master 1 (aux)
//     last_owner   in   last granted master (only with MIO_ARB_RR_EN)
//     grant_valid  out  at least one master requests
//     grant_idx    out  index of the winning master
//   Macro MIO_ARB_RR_EN: on a tie the master opposite to last_owner wins.
//   Without it master 0 always wins a tie and no pointer input exists.
module mio_arb_pick
   import mio_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
`ifdef MIO_ARB_RR_EN
   input  logic last_owner,
`endif
   output logic grant_valid,
   output logic grant_idx
);

   // Winner select: a single requester always wins, ties resolved by policy
   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = M_CPU;
      if (req0 && req1) begin
`ifdef MIO_ARB_RR_EN
         grant_idx = ~last_owner;
`else
         grant_idx = M_CPU;
`endif
      end else if (req1) begin
         grant_idx = M_AUX;
      end else begin
         grant_idx = M_CPU;
      end
   end

endmodule

// File: rtl/mio_arbiter.sv
// mio_arbiter: shares one memory/IO port between the CPU (master 0) and an
// auxiliary master (master 1). One access at a time is sequenced through
// IDLE -> ACCESS -> RESP; the winner receives a one-cycle ack, read data on
// m_rdata and an error flag when memory did not answer within TIMEOUT cycles.
//   Parameters: AW address width, DW data width, TIMEOUT wait limit (1..255)
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     mX_req/mX_we/mX_addr/mX_wdata   master request, held until its ack
//     mX_ack/mX_err                   one-cycle completion pulse and timeout flag
//     m_rdata                         read data, valid in the ack cycle
//     mem_req/mem_we/mem_addr/mem_wdata  latched request toward memory
//     mem_ready/mem_rdata             memory completion and read data
//     owner                           current / last granted master
//   Macro MIO_ARB_RR_EN: round-robin tie break (default: CPU wins ties).
//   All outputs come straight from registers.
module mio_arbiter
   import mio_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = MIO_TIMEOUT_DEF
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [DW-1:0] m_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   // Registered state and outputs
   logic [1:0]       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             owner_r;
   logic             mem_req_r;
   logic             mem_we_r;
   logic [AW-1:0]    mem_addr_r;
   logic [DW-1:0]    mem_wdata_r;
   logic [DW-1:0]    m_rdata_r;
   logic [1:0]       ack_r;
   logic [1:0]       err_r;

   // Next-state values
   logic [1:0]       state_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             owner_nxt_s;
   logic             mem_req_nxt_s;
   logic             mem_we_nxt_s;
   logic [AW-1:0]    mem_addr_nxt_s;
   logic [DW-1:0]    mem_wdata_nxt_s;
   logic [DW-1:0]    m_rdata_nxt_s;
   logic [1:0]       ack_nxt_s;
   logic [1:0]       err_nxt_s;

   // Arbitration result
   logic             grant_valid_s;
   logic             grant_idx_s;

   mio_arb_pick u_pick (
      .req0        (m0_req),
      .req1        (m1_req),
`ifdef MIO_ARB_RR_EN
      // owner_r doubles as the round-robin pointer: it changes on every grant
      .last_owner  (owner_r),
`endif
      .grant_valid (grant_valid_s),
      .grant_idx   (grant_idx_s)
   );

   // Next-state and next-output computation for the access sequencer
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      owner_nxt_s     = owner_r;
      mem_req_nxt_s   = mem_req_r;
      mem_we_nxt_s    = mem_we_r;
      mem_addr_nxt_s  = mem_addr_r;
      mem_wdata_nxt_s = mem_wdata_r;
      m_rdata_nxt_s   = m_rdata_r;
      ack_nxt_s       = 2'b00;
      err_nxt_s       = 2'b00;

      case (state_r)
         ST_IDLE: begin
            // Master inputs are only looked at here; they are latched on grant
            if (grant_valid_s) begin
               state_nxt_s   = ST_ACCESS;
               owner_nxt_s   = grant_idx_s;
               cnt_nxt_s     = {CNT_W{1'b0}};
               mem_req_nxt_s = 1'b1;
               if (grant_idx_s == M_AUX) begin
                  mem_we_nxt_s    = m1_we;
                  mem_addr_nxt_s  = m1_addr;
                  mem_wdata_nxt_s = m1_wdata;
               end else begin
                  mem_we_nxt_s    = m0_we;
                  mem_addr_nxt_s  = m0_addr;
                  mem_wdata_nxt_s = m0_wdata;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_ACCESS: begin
            // Ready wins over timeout if both happen in the same cycle
            if (mem_ready) begin
               state_nxt_s   = ST_RESP;
               mem_req_nxt_s = 1'b0;
               m_rdata_nxt_s = mem_rdata;
               ack_nxt_s     = owner_onehot(owner_r);
               err_nxt_s     = 2'b00;
            end else if (cnt_r == TIMEOUT_CNT) begin
               state_nxt_s   = ST_RESP;
               mem_req_nxt_s = 1'b0;
               m_rdata_nxt_s = {DW{1'b0}};
               ack_nxt_s     = owner_onehot(owner_r);
               err_nxt_s     = owner_onehot(owner_r);
            end else begin
               cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end

         ST_RESP: begin
            // Ack is visible this cycle; return to IDLE so the acked master
            // has a cycle to drop its request before inputs are sampled again
            state_nxt_s = ST_IDLE;
         end

         default: begin
            state_nxt_s   = ST_IDLE;
            mem_req_nxt_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset returns everything to idle values
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         owner_r     <= M_CPU;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
         m_rdata_r   <= {DW{1'b0}};
         ack_r       <= 2'b00;
         err_r       <= 2'b00;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         owner_r     <= owner_nxt_s;
         mem_req_r   <= mem_req_nxt_s;
         mem_we_r    <= mem_we_nxt_s;
         mem_addr_r  <= mem_addr_nxt_s;
         mem_wdata_r <= mem_wdata_nxt_s;
         m_rdata_r   <= m_rdata_nxt_s;
         ack_r       <= ack_nxt_s;
         err_r       <= err_nxt_s;
      end
   end

   assign m0_ack    = ack_r[0];
   assign m1_ack    = ack_r[1];
   assign m0_err    = err_r[0];
   assign m1_err    = err_r[1];
   assign m_rdata   = m_rdata_r;
   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign owner     = owner_r;

endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter: directed self-checking bench for mio_arbiter (TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mio_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk;
   logic          reset;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_ack, m0_err, m1_ack, m1_err;
   logic [DW-1:0] m_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          owner;

   int n_cmp;
   int n_bad;

   mio_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err),
      .m_rdata(m_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle at the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      tick(); tick();
      reset = 1'b0;
      n_cmp++;
      if ({mem_req, mem_we, m0_ack, m1_ack, m0_err, m1_err, owner} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_ctl: got %b expected 0000000",
                  {mem_req, mem_we, m0_ack, m1_ack, m0_err, m1_err, owner});
      end
      n_cmp++;
      if (mem_addr !== 32'h0) begin
         n_bad++; $display("FAIL reset_addr: got %h expected 00000000", mem_addr);
      end
      n_cmp++;
      if (mem_wdata !== 32'h0) begin
         n_bad++; $display("FAIL reset_wdata: got %h expected 00000000", mem_wdata);
      end
      n_cmp++;
      if (m_rdata !== 32'h0) begin
         n_bad++; $display("FAIL reset_rdata: got %h expected 00000000", m_rdata);
      end
   endtask

   task automatic test_cpu_read();
      logic m1_seen;
      m1_seen = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0040; m0_wdata = 32'h1111_1111;
      tick();  // grant edge
      m1_seen = m1_seen | m1_ack;
      n_cmp++;
      if ({mem_req, mem_we, owner} !== 3'b100 || mem_addr !== 32'h0000_0040) begin
         n_bad++;
         $display("FAIL cpu_grant: got req/we/owner=%b addr=%h expected 100 addr=00000040",
                  {mem_req, mem_we, owner}, mem_addr);
      end
      tick();  // first wait cycle, memory not ready
      m1_seen = m1_seen | m1_ack;
      n_cmp++;
      if (m0_ack !== 1'b0 || mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL cpu_wait: got ack=%b mem_req=%b expected ack=0 mem_req=1", m0_ack, mem_req);
      end
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      tick();  // ready sampled, ack cycle
      m1_seen = m1_seen | m1_ack;
      n_cmp++;
      if ({m0_ack, m0_err, mem_req} !== 3'b100 || m_rdata !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL cpu_ack: got ack/err/mem_req=%b rdata=%h expected 100 rdata=12345678",
                  {m0_ack, m0_err, mem_req}, m_rdata);
      end
      m0_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      tick();
      m1_seen = m1_seen | m1_ack;
      n_cmp++;
      if (m0_ack !== 1'b0 || m_rdata !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL cpu_ack_pulse: got ack=%b rdata=%h expected ack=0 rdata=12345678",
                  m0_ack, m_rdata);
      end
      n_cmp++;
      if (m1_seen !== 1'b0) begin
         n_bad++; $display("FAIL cpu_no_m1_ack: got m1_ack seen=%b expected 0", m1_seen);
      end
   endtask

   task automatic test_simultaneous();
      logic first, second;
      // owner is 0 here (last grant went to the CPU)
`ifdef MIO_ARB_RR_EN
      first = 1'b1;
`else
      first = 1'b0;
`endif
      second = ~first;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0020;
      tick();
      n_cmp++;
      if (owner !== first || mem_addr !== (first ? 32'h0000_0020 : 32'h0000_0010)) begin
         n_bad++;
         $display("FAIL tie_first_grant: got owner=%b addr=%h expected owner=%b", owner, mem_addr, first);
      end
      mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
      tick();
      n_cmp++;
      if ({m1_ack, m0_ack} !== (first ? 2'b10 : 2'b01)) begin
         n_bad++;
         $display("FAIL tie_first_ack: got m1/m0 ack=%b expected winner %b", {m1_ack, m0_ack}, first);
      end
      if (first) m1_req = 1'b0; else m0_req = 1'b0;
      mem_ready = 1'b0;
      tick();  // RESP -> IDLE
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_bad++; $display("FAIL tie_idle_gap: got mem_req=%b expected 0", mem_req);
      end
      tick();  // IDLE grants the remaining master
      n_cmp++;
      if (mem_req !== 1'b1 || owner !== second ||
          mem_addr !== (second ? 32'h0000_0020 : 32'h0000_0010)) begin
         n_bad++;
         $display("FAIL tie_second_grant: got mem_req=%b owner=%b addr=%h expected owner=%b",
                  mem_req, owner, mem_addr, second);
      end
      mem_ready = 1'b1; mem_rdata = 32'hA5A5_0002;
      tick();
      n_cmp++;
      if ({m1_ack, m0_ack} !== (second ? 2'b10 : 2'b01) || m_rdata !== 32'hA5A5_0002) begin
         n_bad++;
         $display("FAIL tie_second_ack: got m1/m0 ack=%b rdata=%h expected winner %b rdata=a5a50002",
                  {m1_ack, m0_ack}, m_rdata, second);
      end
      m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_aux_write();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0100; m1_wdata = 32'hDEAD_BEEF;
      tick();
      n_cmp++;
      if ({mem_req, mem_we, owner} !== 3'b111 || mem_addr !== 32'h0000_0100 ||
          mem_wdata !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL aux_write_grant: got req/we/owner=%b addr=%h data=%h expected 111 00000100 deadbeef",
                  {mem_req, mem_we, owner}, mem_addr, mem_wdata);
      end
      // Changes during ACCESS must not reach the memory side
      m1_addr = 32'h0000_0200; m1_wdata = 32'h0; m1_we = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({mem_req, mem_we, m1_ack} !== 3'b110 || mem_addr !== 32'h0000_0100 ||
          mem_wdata !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL aux_write_hold: got req/we/ack=%b addr=%h data=%h expected 110 00000100 deadbeef",
                  {mem_req, mem_we, m1_ack}, mem_addr, mem_wdata);
      end
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      n_cmp++;
      if ({m1_ack, m1_err, m0_ack, mem_req} !== 4'b1000) begin
         n_bad++;
         $display("FAIL aux_write_ack: got m1ack/m1err/m0ack/mem_req=%b expected 1000",
                  {m1_ack, m1_err, m0_ack, mem_req});
      end
      m1_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int  lat;
      logic req_dropped;
      lat = -1;
      req_dropped = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0044;
      tick();  // mem_req rises at this edge
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++; $display("FAIL timeout_start: got mem_req=%b expected 1", mem_req);
      end
      // Ack lands in the 6th cycle counting the mem_req-rise cycle as the first
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (m0_ack === 1'b1) begin
            lat = i;
            break;
         end
         if (mem_req !== 1'b1) req_dropped = 1'b1;
      end
      n_cmp++;
      if (lat != TO + 1) begin
         n_bad++; $display("FAIL timeout_latency: got %0d edges expected %0d", lat, TO + 1);
      end
      n_cmp++;
      if ({m0_err, m1_ack, req_dropped} !== 3'b100 || m_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL timeout_err: got err/m1ack/early_drop=%b rdata=%h expected 100 rdata=00000000",
                  {m0_err, m1_ack, req_dropped}, m_rdata);
      end
      m0_req = 1'b0;
      tick();
      n_cmp++;
      if ({m0_ack, m0_err} !== 2'b00) begin
         n_bad++; $display("FAIL timeout_clear: got ack/err=%b expected 00", {m0_ack, m0_err});
      end
   endtask

   task automatic test_reset_mid_access();
      logic ack_seen;
      ack_seen = 1'b0;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0300; m1_wdata = 32'h7777_8888;
      tick();
      tick();
      n_cmp++;
      if (mem_req !== 1'b1 || owner !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_pre: got mem_req=%b owner=%b expected 1 1", mem_req, owner);
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({mem_req, mem_we, m0_ack, m1_ack, m0_err, m1_err, owner} !== 7'b0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0 || m_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: got ctl=%b addr=%h data=%h rdata=%h expected all zero",
                  {mem_req, mem_we, m0_ack, m1_ack, m0_err, m1_err, owner},
                  mem_addr, mem_wdata, m_rdata);
      end
      m1_req = 1'b0;
      reset = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         ack_seen = ack_seen | m0_ack | m1_ack | mem_req;
      end
      mem_ready = 1'b0;
      n_cmp++;
      if (ack_seen !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid_no_ack: got ack/req activity=%b expected 0", ack_seen);
      end
   endtask

   task automatic test_ready_idle();
      mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
      tick();
      mem_ready = 1'b0;
      n_cmp++;
      if ({m0_ack, m1_ack, mem_req} !== 3'b000 || m_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL ready_idle: got ack0/ack1/mem_req=%b rdata=%h expected 000 00000000",
                  {m0_ack, m1_ack, mem_req}, m_rdata);
      end
      tick();
      n_cmp++;
      if ({m0_ack, m1_ack, mem_req} !== 3'b000) begin
         n_bad++;
         $display("FAIL ready_idle_after: got %b expected 000", {m0_ack, m1_ack, mem_req});
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      @(negedge clk);
      test_reset();
      test_cpu_read();
      test_simultaneous();
      test_aux_write();
      test_timeout();
      test_reset_mid_access();
      test_ready_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Run-time bound in case the sequence above stalls
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish within 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Shares the single memory/IO (MIO) port between two bus masters: the multi-cycle CPU (master 0) and a secondary master (master 1, e.g. debug loader or VGA/DMA engine). It sequences one access at a time through a request/ready handshake toward memory, returns read data and a one-cycle acknowledge to the winning master, and aborts stalled accesses with a timeout error. It sits between the CPU's IorD/MemRead/MemWrite address path and the memory/peripheral decoder that drives `MIO_ready`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, max cycles to wait for `mem_ready` before abort (1..255)

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `m0_req` / `m1_req`  in  1  access request, held until matching ack
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read
- `m0_addr` / `m1_addr`  in  AW  byte address
- `m0_wdata` / `m1_wdata`  in  DW  write data
- `m0_ack` / `m1_ack`  out  1  one-cycle completion pulse
- `m0_err` / `m1_err`  out  1  valid with ack; 1 = timed out
- `m_rdata`  out  DW  read data, valid in ack cycle, shared by both masters
- `mem_req`  out  1  request to memory, held for whole access
- `mem_we`  out  1  write strobe, qualified by `mem_req`
- `mem_addr`  out  AW  latched address
- `mem_wdata`  out  DW  latched write data
- `mem_ready`  in  1  memory completion (MIO_ready)
- `mem_rdata`  in  DW  memory read data, valid with `mem_ready`
- `owner`  out  1  index of current/last granted master (debug)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any `mX_req`, pick winner, latch its we/addr/wdata into `mem_*` regs, set `owner`, clear timeout counter, go ACCESS. No request: stay.
- Pick: fixed priority, master 0 wins when both request (see Configuration).
- ACCESS: `mem_req`=1. On `mem_ready`=1: capture `mem_rdata` into `m_rdata`, err=0, go RESP. Else counter++; when counter reaches `TIMEOUT` with no ready: `m_rdata`=0, err=1, go RESP.
- RESP: `mX_ack`=1 for winner only, `mX_err` per result; `mem_req`=0; go IDLE.
- Inputs sampled only in IDLE; changes to a master's req/addr/data during ACCESS have no effect. Requester dropping req mid-access: access completes, ack still pulses.
- `mem_ready` outside ACCESS: ignored.
- Counter width 8 bits, saturating not required (exits at `TIMEOUT`).

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `m_rdata`=0, both acks/errs=0, `owner`=0, counter=0, RR pointer=0.
- Request seen in IDLE at edge N -> `mem_req` high from N+1.
- `mem_ready` sampled at edge M -> ack high during cycle M+1 -> IDLE at M+2.
- Minimum access: 3 cycles request-to-ack with `mem_ready` tied high; back-to-back grants separated by one IDLE cycle.
- Timeout: ack with err asserted `TIMEOUT`+2 cycles after `mem_req` rises.
- Reset mid-ACCESS: `mem_req` drops next edge, no ack issued, access abandoned.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `MIO_ARB_RR_EN` defined: round-robin; on simultaneous requests, master opposite to the last granted wins; pointer updates on each grant.
- Not defined: fixed priority, master 0 (CPU) always wins; pointer logic absent.

## Structure
- Package `mio_arb_pkg`: state enum (IDLE/ACCESS/RESP), master index constants `M_CPU`=0, `M_AUX`=1, default `TIMEOUT` constant.
- Sub-module `mio_arb_pick`: combinational winner select from two reqs plus last-owner pointer, macro-dependent.

## Test plan
- CPU read alone, `mem_ready` after 2 cycles, `mem_rdata`=0x1234_5678 -> `m0_ack` pulse with `m_rdata`=0x1234_5678, `m0_err`=0, `m1_ack` never high.
- Both request same cycle, fixed priority -> m0 served first, m1 served after one IDLE; with `MIO_ARB_RR_EN` and owner=0 -> m1 first.
- m1 write addr 0x100, data 0xDEAD_BEEF -> `mem_we`=1, `mem_addr`=0x100, `mem_wdata`=0xDEAD_BEEF held until `mem_ready`.
- `TIMEOUT`=4, `mem_ready` never asserts -> `m0_ack`+`m0_err` 6 cycles after `mem_req` rises, `m_rdata`=0.
- Reset asserted during ACCESS -> next cycle `mem_req`=0, no ack, all outputs at reset values.
- `mem_ready` pulsed while IDLE -> no ack, no state change.
